aes_tx_ser: RTL and testbench

Parametrised block-to-lane serializer for the AES verification platform port, sitting between the ciphertext FIFO (first-word-fall-through) and the chip's narrow output pins. It pops one BLOCK_W-bit block, emits it as LANES = BLOCK_W/LANE_W lanes on `tx`, one lane per `en` tick, and signals each new lane with a `shakehand` toggle. A one-block prefetch buffer lets consecutive blocks stream with no idle tick between them.

---
 rtl/aes_tx_ser.sv | 136 +++++++++++++
 tb/tb_aes_tx_ser.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_tx_ser.sv
// Block-to-lane serializer: pops BLOCK_W-bit words from a FWFT FIFO and emits LANE_W lanes on en ticks.
// Latency: lane 0 appears on the first en edge at or after one cycle past the pop; prefetch buffer removes gaps between blocks.
// Backpressure: pops only when the prefetch buffer is free or draining this cycle; optional parity via AES_TX_PARITY_EN.
module aes_tx_ser #(
    parameter int BLOCK_W   = 128,
    parameter int LANE_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [BLOCK_W-1:0] data,
    input  logic               empty,
    output logic               require,
    output logic               shakehand,
    output logic [LANE_W-1:0]  tx,
    output logic               sof,
    output logic               busy
`ifdef AES_TX_PARITY_EN
    ,
    output logic               parity
`endif
);

    localparam int LANES = BLOCK_W / LANE_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic               ready_q;
    logic [BLOCK_W-1:0] buf_q, buf_d;
    logic               buf_vld_q, buf_vld_d;
    logic [BLOCK_W-1:0] cur_q, cur_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LANE_W-1:0]  tx_q, tx_d;
    logic               sof_q, sof_d;
    logic               sh_q, sh_d;
    logic               par_q, par_d;
    logic               move;
    logic               at_last;
    logic [LANE_W-1:0]  lane_nxt;

    function automatic logic [LANE_W-1:0] lane_of(input logic [BLOCK_W-1:0] w,
                                                  input logic [IDX_W-1:0]   i);
        int sh;
        sh = (MSB_FIRST != 0) ? (LANES - 1 - int'(i)) * LANE_W : int'(i) * LANE_W;
        return LANE_W'(w >> sh);
    endfunction

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        cur_d     = cur_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        sof_d     = sof_q;
        sh_d      = sh_q;
        par_d     = par_q;

        at_last = (idx_q == LAST);
        move    = en & buf_vld_q & ((state_q == IDLE) | at_last);
        require = ready_q & ~empty & (~buf_vld_q | move);

        // A pop on the same edge as a move refills the buffer with the new head word.
        if (require) begin
            buf_d     = data;
            buf_vld_d = 1'b1;
        end else if (move) begin
            buf_vld_d = 1'b0;
        end

        lane_nxt = move ? lane_of(buf_q, '0) : lane_of(cur_q, idx_q + 1'b1);

        if (move) begin
            cur_d   = buf_q;
            idx_d   = '0;
            tx_d    = lane_nxt;
            par_d   = ^lane_nxt;
            sh_d    = ~sh_q;
            sof_d   = 1'b1;
            state_d = SEND;
        end else if (en && state_q == SEND) begin
            if (!at_last) begin
                idx_d = idx_q + 1'b1;
                tx_d  = lane_nxt;
                par_d = ^lane_nxt;
                sh_d  = ~sh_q;
                sof_d = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            cur_q     <= '0;
            idx_q     <= '0;
            tx_q      <= '0;
            sof_q     <= 1'b0;
            sh_q      <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= 1'b1;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            cur_q     <= cur_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            sof_q     <= sof_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
        end
    end

    assign tx        = tx_q;
    assign sof       = sof_q;
    assign shakehand = sh_q;
    assign busy      = (state_q == SEND) | buf_vld_q;

`ifdef AES_TX_PARITY_EN
    assign parity = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_aes_tx_ser.sv
// Scoreboarded bench for aes_tx_ser: 128/8 MSB-first instance and 128/32 LSB-first instance.
module tb_aes_tx_ser;

    typedef struct {
        logic [31:0] lane;
        logic        sof;
        logic        par;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en_a;
    logic         en_b;
    logic [127:0] data_a, data_b;
    logic         empty_a, empty_b;
    logic         require_a, require_b;
    logic         sh_a, sh_b;
    logic [7:0]   tx_a;
    logic [31:0]  tx_b;
    logic         sof_a, sof_b;
    logic         busy_a, busy_b;
`ifdef AES_TX_PARITY_EN
    logic         parity_a, parity_b;
`endif

    always #5 clk = ~clk;

    aes_tx_ser #(.BLOCK_W(128), .LANE_W(8), .MSB_FIRST(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .data(data_a), .empty(empty_a),
        .require(require_a), .shakehand(sh_a), .tx(tx_a), .sof(sof_a), .busy(busy_a)
`ifdef AES_TX_PARITY_EN
        , .parity(parity_a)
`endif
    );

    aes_tx_ser #(.BLOCK_W(128), .LANE_W(32), .MSB_FIRST(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .data(data_b), .empty(empty_b),
        .require(require_b), .shakehand(sh_b), .tx(tx_b), .sof(sof_b), .busy(busy_b)
`ifdef AES_TX_PARITY_EN
        , .parity(parity_b)
`endif
    );

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           en_div = 1;
    logic [127:0] fifo_a[$];
    logic [127:0] fifo_b[$];
    exp_t         exp_a[$];
    exp_t         exp_b[$];
    int           tog_cyc[$];
    int           req_cyc[$];
    logic         req_a_lat = 1'b0, req_b_lat = 1'b0;
    logic         sh_prev_a = 1'b0, sh_prev_b = 1'b0, en_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic refresh();
        empty_a = (fifo_a.size() == 0);
        data_a  = empty_a ? '0 : fifo_a[0];
        empty_b = (fifo_b.size() == 0);
        data_b  = empty_b ? '0 : fifo_b[0];
    endtask

    task automatic push_exp_a(input logic [127:0] w);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.lane = {24'h0, w[127-8*i -: 8]};
            e.sof  = (i == 0);
            e.par  = ^w[127-8*i -: 8];
            exp_a.push_back(e);
        end
    endtask

    task automatic push_a(input logic [127:0] w);
        fifo_a.push_back(w);
        push_exp_a(w);
        refresh();
    endtask

    task automatic push_b(input logic [127:0] w);
        exp_t e;
        fifo_b.push_back(w);
        for (int i = 0; i < 4; i++) begin
            e.lane = w[32*i +: 32];
            e.sof  = (i == 0);
            e.par  = ^w[32*i +: 32];
            exp_b.push_back(e);
        end
        refresh();
    endtask

    // One clock: observe outputs on the falling edge, then model the FIFO pop and drive inputs after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        req_a_lat = require_a;
        req_b_lat = require_b;
        if (rst_n) begin
            if (require_a) begin
                req_cyc.push_back(cyc);
                check_eq("req_while_empty", 64'(empty_a), 64'(0));
            end
            if (sh_a !== sh_prev_a) begin
                tog_cyc.push_back(cyc);
                check_eq("toggle_without_en", 64'(en_prev), 64'(1));
                check_eq("lane_unexpected_a", 64'(exp_a.size() > 0), 64'(1));
                if (exp_a.size() > 0) begin
                    e = exp_a.pop_front();
                    check_eq("tx_a", 64'(tx_a), 64'(e.lane));
                    check_eq("sof_a", 64'(sof_a), 64'(e.sof));
`ifdef AES_TX_PARITY_EN
                    check_eq("parity_a", 64'(parity_a), 64'(e.par));
`endif
                end
            end
            if (sh_b !== sh_prev_b) begin
                check_eq("lane_unexpected_b", 64'(exp_b.size() > 0), 64'(1));
                if (exp_b.size() > 0) begin
                    e = exp_b.pop_front();
                    check_eq("tx_b", 64'(tx_b), 64'(e.lane));
                    check_eq("sof_b", 64'(sof_b), 64'(e.sof));
                end
            end
        end
        sh_prev_a = sh_a;
        sh_prev_b = sh_b;
        en_prev   = en_a;
        @(posedge clk);
        #1;
        cyc++;
        if (req_a_lat && fifo_a.size() > 0) void'(fifo_a.pop_front());
        if (req_b_lat && fifo_b.size() > 0) void'(fifo_b.pop_front());
        en_a = ((cyc % en_div) == 0);
        refresh();
    endtask

    task automatic drain(input int budget);
        int b = budget;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && b > 0) begin
            tick();
            b--;
        end
        check_eq("drain_timeout", 64'(exp_a.size() + exp_b.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] w;
        int t0, r0, b;
        rst_n = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        refresh();
        repeat (3) tick();
        check_eq("rst_tx", 64'(tx_a), 64'(0));
        check_eq("rst_sh", 64'(sh_a), 64'(0));
        check_eq("rst_sof", 64'(sof_a), 64'(0));
        check_eq("rst_busy", 64'(busy_a), 64'(0));
        check_eq("rst_require", 64'(require_a), 64'(0));
`ifdef AES_TX_PARITY_EN
        check_eq("rst_parity", 64'(parity_a), 64'(0));
`endif

        // Single block 00..0F, plus the 32-bit LSB-first lane instance.
        w = '0;
        for (int i = 0; i < 16; i++) w = (w << 8) | 128'(i);
        push_a(w);
        push_b(128'h33333333_22222222_11111111_00000000);
        rst_n = 1'b1;
        #1;
        check_eq("req_after_release", 64'(require_a), 64'(0));
        r0 = req_cyc.size();
        t0 = tog_cyc.size();
        drain(200);
        repeat (4) tick();
        check_eq("t1_toggles", 64'(tog_cyc.size() - t0), 64'(16));
        check_eq("t1_span", 64'(tog_cyc[t0+15] - tog_cyc[t0]), 64'(15));
        check_eq("t1_latency", 64'(tog_cyc[t0] - req_cyc[r0]), 64'(2));
        check_eq("t1_pops", 64'(req_cyc.size() - r0), 64'(1));
        check_eq("t1_busy", 64'(busy_a), 64'(0));
        check_eq("t1_tx_hold", 64'(tx_a), 64'(8'h0f));
        check_eq("t1_sof_hold", 64'(sof_a), 64'(0));
        check_eq("t4_busy_b", 64'(busy_b), 64'(0));

        // Two blocks back-to-back.
        r0 = req_cyc.size();
        t0 = tog_cyc.size();
        push_a({$urandom, $urandom, $urandom, $urandom});
        push_a({$urandom, $urandom, $urandom, $urandom});
        drain(200);
        repeat (4) tick();
        check_eq("t2_toggles", 64'(tog_cyc.size() - t0), 64'(32));
        check_eq("t2_span", 64'(tog_cyc[t0+31] - tog_cyc[t0]), 64'(31));
        check_eq("t2_pops", 64'(req_cyc.size() - r0), 64'(2));
        check_eq("t2_second_pop_early", 64'(req_cyc[r0+1] < tog_cyc[t0] + 16), 64'(1));

        // Lane rate of one in four, idle gap, restart.
        en_div = 4;
        t0 = tog_cyc.size();
        push_a({$urandom, $urandom, $urandom, $urandom});
        drain(400);
        repeat (8) tick();
        check_eq("t3_toggles", 64'(tog_cyc.size() - t0), 64'(16));
        check_eq("t3_span", 64'(tog_cyc[t0+15] - tog_cyc[t0]), 64'(60));
        t0 = tog_cyc.size();
        repeat (20) tick();
        check_eq("t3_idle_toggles", 64'(tog_cyc.size() - t0), 64'(0));
        check_eq("t3_idle_busy", 64'(busy_a), 64'(0));
        push_a({$urandom, $urandom, $urandom, $urandom});
        drain(400);
        repeat (8) tick();
        check_eq("t3_restart_toggles", 64'(tog_cyc.size() - t0), 64'(16));
        en_div = 1;

        // Reset after lane 5 with one block buffered and one still in the FIFO.
        repeat (2) tick();
        push_a({$urandom, $urandom, $urandom, $urandom});
        push_a({$urandom, $urandom, $urandom, $urandom});
        push_a({$urandom, $urandom, $urandom, $urandom});
        t0 = tog_cyc.size();
        b = 100;
        while (tog_cyc.size() - t0 < 6 && b > 0) begin
            tick();
            b--;
        end
        check_eq("t5_reach_lane5", 64'(tog_cyc.size() - t0 >= 6), 64'(1));
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_tx", 64'(tx_a), 64'(0));
        check_eq("t5_rst_sh", 64'(sh_a), 64'(0));
        check_eq("t5_rst_sof", 64'(sof_a), 64'(0));
        check_eq("t5_rst_busy", 64'(busy_a), 64'(0));
        check_eq("t5_rst_require", 64'(require_a), 64'(0));
        exp_a.delete();
        repeat (2) tick();
        check_eq("t5_fifo_left", 64'(fifo_a.size()), 64'(1));
        if (fifo_a.size() > 0) push_exp_a(fifo_a[0]);
        rst_n = 1'b1;
        t0 = tog_cyc.size();
        drain(200);
        repeat (4) tick();
        check_eq("t5_toggles", 64'(tog_cyc.size() - t0), 64'(16));
        check_eq("t5_fifo_empty", 64'(fifo_a.size()), 64'(0));
        check_eq("t5_busy", 64'(busy_a), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
